bsg_fifos_to_axil: RTL and testbench

- AXI-Lite initiator (master) that turns a ready/valid command FIFO stream into single AXI-Lite read or write transactions.
- Returns each completion as a response on a ready/valid stream.
- Host-side counterpart of the AXI-Lite-to-FIFO slave adapter; drives that adapter's per-slot registers (tx_data, rx_data, vacancy, occupancy) from a bench or host model.
- Exactly one transaction outstanding at a time.

---
 rtl/bsg_fifos_to_axil.sv | 197 +++++++++++++++++++
 tb/tb_bsg_fifos_to_axil.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fifos_to_axil.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_fifos_to_axil: AXI-Lite initiator, one outstanding command->response |
// | Optional watchdog: define BSG_FIFOS_TO_AXIL_TIMEOUT_EN                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bsg_fifos_to_axil #(
    parameter int timeout_p     = 1024,
    parameter int count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     cmd_v_i,
    input  logic                     cmd_write_i,
    input  logic [31:0]              cmd_addr_i,
    input  logic [31:0]              cmd_data_i,
    input  logic [3:0]               cmd_strb_i,
    output logic                     cmd_ready_o,

    output logic                     resp_v_o,
    output logic                     resp_write_o,
    output logic [31:0]              resp_data_o,
    output logic [1:0]               resp_err_o,
    input  logic                     resp_ready_i,

    // mosi {awaddr,awprot,awvalid,wdata,wstrb,wvalid,bready,araddr,arprot,arvalid,rready}
    output logic [110:0]             m_axil_bus_o,
    // miso {awready,wready,bresp,bvalid,arready,rdata,rresp,rvalid}
    input  logic [40:0]              m_axil_bus_i,

    output logic [count_width_p-1:0] wr_count_o,
    output logic [count_width_p-1:0] rd_count_o,
    output logic                     timeout_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic        w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic [1:0]  w_bresp, w_rresp;
    logic [31:0] w_rdata;

    assign {w_awready, w_wready, w_bresp, w_bvalid,
            w_arready, w_rdata, w_rresp, w_rvalid} = m_axil_bus_i;

    logic                     w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
    logic [31:0]              r_addr, r_wdata, r_resp_data;
    logic [3:0]               r_wstrb;
    logic                     r_write, r_aw_done, r_w_done;
    logic [1:0]               r_resp_err;
    logic [count_width_p-1:0] r_wr_count, r_rd_count;

    logic w_accept, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign cmd_ready_o = (r_state == IDLE) && reset_n_i;
    assign w_accept    = cmd_v_i && cmd_ready_o;
    assign w_aw_hs     = w_awvalid && w_awready;
    assign w_w_hs      = w_wvalid  && w_wready;
    assign w_b_hs      = w_bready  && w_bvalid;
    assign w_ar_hs     = w_arvalid && w_arready;
    assign w_r_hs      = w_rready  && w_rvalid;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = cmd_write_i ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                // aw and w channels complete independently; never re-raise a finished one
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || (!r_aw_done && w_awready)) &&
                    (r_w_done  || (!r_w_done  && w_wready)))
                    w_state_next = WR_RESP;
            end
            WR_RESP: begin
                w_bready = 1'b1;
                if (w_bvalid) w_state_next = DONE;
            end
            RD_REQ: begin
                w_arvalid = 1'b1;
                if (w_arready) w_state_next = RD_RESP;
            end
            RD_RESP: begin
                w_rready = 1'b1;
                if (w_rvalid) w_state_next = DONE;
            end
            DONE: begin
                if (resp_ready_i) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_write     <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= '0;
            r_wr_count  <= '0;
            r_rd_count  <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_addr_i;
                r_wdata   <= cmd_data_i;
                r_wstrb   <= cmd_strb_i;
                r_write   <= cmd_write_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_b_hs) begin
                r_resp_data <= '0;
                r_resp_err  <= w_bresp;
                r_wr_count  <= r_wr_count + count_width_p'(1);
            end
            if (w_r_hs) begin
                r_resp_data <= w_rdata;
                r_resp_err  <= w_rresp;
                r_rd_count  <= r_rd_count + count_width_p'(1);
            end
        end
    end

    assign resp_v_o     = (r_state == DONE);
    assign resp_write_o = r_write;
    assign resp_data_o  = r_resp_data;
    assign resp_err_o   = r_resp_err;
    assign wr_count_o   = r_wr_count;
    assign rd_count_o   = r_rd_count;

    assign m_axil_bus_o = {r_addr, 3'b000, w_awvalid, r_wdata, r_wstrb, w_wvalid, w_bready,
                           r_addr, 3'b000, w_arvalid, w_rready};

`ifdef BSG_FIFOS_TO_AXIL_TIMEOUT_EN
    localparam int c_to_width = $clog2(timeout_p + 1);
    localparam logic [c_to_width-1:0] c_to_limit = c_to_width'(timeout_p);
    localparam logic [c_to_width-1:0] c_to_last  = c_to_width'(timeout_p - 1);

    logic [c_to_width-1:0] r_to_cnt;
    logic                  r_timeout;
    logic                  w_busy_cur, w_busy_next, w_to_clear;

    assign w_busy_cur  = (r_state != IDLE) && (r_state != DONE);
    assign w_busy_next = (w_state_next != IDLE) && (w_state_next != DONE);
    assign w_to_clear  = (w_busy_next && (w_state_next != r_state)) ||
                         w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;

    // Counter saturates at the limit so the flag edge is seen exactly once
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_to_clear) begin
            r_to_cnt <= '0;
        end else if (w_busy_cur && (r_to_cnt != c_to_limit)) begin
            r_to_cnt <= r_to_cnt + c_to_width'(1);
            if (r_to_cnt == c_to_last) r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (timeout_p != 0);
    assign timeout_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_fifos_to_axil.sv
`default_nettype none
// Directed bench for bsg_fifos_to_axil with a small configurable AXI-Lite slave.
module tb_bsg_fifos_to_axil;

`ifdef BSG_FIFOS_TO_AXIL_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_v, cmd_write, cmd_ready;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_strb;
    logic        resp_v, resp_write, resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic [110:0] bus_o;
    logic [40:0]  bus_i;
    logic [15:0] wr_count, rd_count;
    logic        timeout;

    always #5 clk = ~clk;

    bsg_fifos_to_axil #(.timeout_p(TO), .count_width_p(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cmd_v_i(cmd_v), .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr),
        .cmd_data_i(cmd_data), .cmd_strb_i(cmd_strb), .cmd_ready_o(cmd_ready),
        .resp_v_o(resp_v), .resp_write_o(resp_write), .resp_data_o(resp_data),
        .resp_err_o(resp_err), .resp_ready_i(resp_ready),
        .m_axil_bus_o(bus_o), .m_axil_bus_i(bus_i),
        .wr_count_o(wr_count), .rd_count_o(rd_count), .timeout_o(timeout)
    );

    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    assign {m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
            m_araddr, m_arprot, m_arvalid, m_rready} = bus_o;

    // Slave model knobs
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit          b_never = 1'b0;
    logic [1:0]  sl_bresp = 2'b00, sl_rresp = 2'b00;
    logic [31:0] sl_rdata = 32'h0;

    int   aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic aw_got, w_got, b_pend, r_pend;
    logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, aw_now, w_now;

    assign s_awready = m_awvalid && (aw_wait >= aw_delay);
    assign s_wready  = m_wvalid  && (w_wait  >= w_delay);
    assign s_bvalid  = b_pend && !b_never && (b_wait >= b_delay);
    assign s_arready = m_arvalid && (ar_wait >= ar_delay);
    assign s_rvalid  = r_pend && (r_wait >= r_delay);
    assign aw_now    = aw_got || (m_awvalid && s_awready);
    assign w_now     = w_got  || (m_wvalid  && s_wready);
    assign bus_i = {s_awready, s_wready, (s_bvalid ? sl_bresp : 2'b00), s_bvalid,
                    s_arready, sl_rdata, (s_rvalid ? sl_rresp : 2'b00), s_rvalid};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_wait <= (m_awvalid && !s_awready) ? aw_wait + 1 : 0;
            w_wait  <= (m_wvalid  && !s_wready)  ? w_wait + 1  : 0;
            ar_wait <= (m_arvalid && !s_arready) ? ar_wait + 1 : 0;
            if (aw_now && w_now) begin
                b_pend <= 1'b1; b_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                aw_got <= aw_now; w_got <= w_now;
            end
            if (b_pend) begin
                if (s_bvalid && m_bready) b_pend <= 1'b0;
                else                      b_wait <= b_wait + 1;
            end
            if (m_arvalid && s_arready) begin
                r_pend <= 1'b1; r_wait <= 0;
            end else if (r_pend) begin
                if (s_rvalid && m_rready) r_pend <= 1'b0;
                else                      r_wait <= r_wait + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        check("cmd_ready before issue", {63'd0, cmd_ready}, 64'd1);
        cmd_v = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_data = data; cmd_strb = strb;
        step();
        cmd_v = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        while (!resp_v && n < 200) begin
            step();
            n++;
        end
        check(name, {63'd0, resp_v}, 64'd1);
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_wr, exp_rd;
        vecs[0] = '{1'b0, 32'h40,   32'h0,  4'hF, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{1'b0, 32'hFFF0, 32'h0,  4'hF, 2'b11, 32'h0,         32'h0,         2'b11};
        vecs[2] = '{1'b1, 32'h44,   32'h1,  4'h1, 2'b10, 32'h1234_5678, 32'h0,         2'b10};
        vecs[3] = '{1'b1, 32'h48,   32'h77, 4'hF, 2'b11, 32'h1234_5678, 32'h0,         2'b11};
        vecs[4] = '{1'b0, 32'h4C,   32'h0,  4'hF, 2'b10, 32'h0000_A5A5, 32'h0000_A5A5, 2'b10};
        vecs[5] = '{1'b1, 32'h0,    32'h9,  4'h3, 2'b00, 32'hFFFF_FFFF, 32'h0,         2'b00};

        reset_n = 1'b0; cmd_v = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_strb = '0; resp_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst resp_v", {63'd0, resp_v}, 64'd0);
        check("rst valids", {59'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
        check("rst addr/data/strb", {m_awaddr, m_wdata ^ {28'd0, m_wstrb}}, 64'd0);
        check("rst counters", {32'd0, wr_count, rd_count}, 64'd0);
        check("rst timeout", {63'd0, timeout}, 64'd0);
        reset_n = 1'b1;
        step();
        check("post-rst cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Zero-wait write: cycle-exact latency
        sl_rdata = 32'h1234_5678;
        issue(1'b1, 32'h10, 32'hCAFE_0001, 4'hF);
        check("w1 c1 aw/w valid", {62'd0, m_awvalid, m_wvalid}, 64'd3);
        check("w1 c1 awaddr", {32'd0, m_awaddr}, 64'h10);
        check("w1 c1 wdata", {32'd0, m_wdata}, 64'hCAFE_0001);
        check("w1 c1 wstrb/prot", {57'd0, m_wstrb, m_awprot}, {57'd0, 4'hF, 3'd0});
        check("w1 c1 cmd_ready", {63'd0, cmd_ready}, 64'd0);
        step();
        check("w1 c2 bready/aw/w", {61'd0, m_bready, m_awvalid, m_wvalid}, 64'b100);
        check("w1 c2 resp_v", {63'd0, resp_v}, 64'd0);
        step();
        check("w1 c3 resp_v", {63'd0, resp_v}, 64'd1);
        check("w1 c3 write/err", {61'd0, resp_write, resp_err}, 64'b100);
        check("w1 c3 data", {32'd0, resp_data}, 64'd0);
        check("w1 c3 wr_count", {48'd0, wr_count}, 64'd1);
        consume();
        check("w1 after consume", {62'd0, resp_v, cmd_ready}, 64'b01);

        // Write with awready delayed 3 cycles
        aw_delay = 3;
        issue(1'b1, 32'h20, 32'h0BAD_F00D, 4'h3);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            check($sformatf("w2 c%0d awvalid", cyc), {63'd0, m_awvalid}, {63'd0, cyc <= 4});
            check($sformatf("w2 c%0d wvalid", cyc), {63'd0, m_wvalid}, {63'd0, cyc == 1});
            if (cyc <= 4) check($sformatf("w2 c%0d awaddr", cyc), {32'd0, m_awaddr}, 64'h20);
            step();
        end
        aw_delay = 0;
        wait_resp("w2 resp arrives");
        check("w2 err/data", {30'd0, resp_err, resp_data}, 64'd0);
        consume();
        begin
            int extra = 0;
            for (int i = 0; i < 5; i++) begin
                if (resp_v) extra++;
                step();
            end
            check("w2 single response", 64'(extra), 64'd0);
        end
        check("w2 wr_count", {48'd0, wr_count}, 64'd2);

        // Read with delayed rvalid, then response held under backpressure
        sl_rdata = 32'h4; sl_rresp = 2'b00; r_delay = 5;
        issue(1'b0, 32'h1C, 32'hFFFF_FFFF, 4'hF);
        check("r1 c1 arvalid/awvalid", {62'd0, m_arvalid, m_awvalid}, 64'b10);
        check("r1 c1 araddr/prot", {29'd0, m_araddr, m_arprot}, {29'd0, 32'h1C, 3'd0});
        step();
        check("r1 c2 rready", {62'd0, m_rready, m_arvalid}, 64'b10);
        wait_resp("r1 resp arrives");
        r_delay = 0;
        sl_rdata = 32'hEEEE_EEEE;
        check("r1 data", {32'd0, resp_data}, 64'h4);
        check("r1 write/err", {61'd0, resp_write, resp_err}, 64'd0);
        check("r1 rd_count", {48'd0, rd_count}, 64'd1);
        cmd_v = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_data = 32'h55; cmd_strb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold cmd_ready", {63'd0, cmd_ready}, 64'd0);
            check("hold resp", {29'd0, resp_v, resp_write, resp_err, resp_data},
                  {29'd0, 1'b1, 1'b0, 2'b00, 32'h4});
        end
        consume();
        check("b2b cmd_ready after consume", {62'd0, resp_v, cmd_ready}, 64'b01);
        step();
        cmd_v = 1'b0;
        check("b2b accepted", {62'd0, cmd_ready, m_awvalid}, 64'b01);
        check("b2b awaddr", {32'd0, m_awaddr}, 64'h30);
        wait_resp("b2b resp arrives");
        consume();
        check("b2b wr_count", {48'd0, wr_count}, 64'd3);

        // Table of transactions with assorted response codes
        exp_wr = 3; exp_rd = 1;
        for (int i = 0; i < 6; i++) begin
            sl_bresp = vecs[i].sresp; sl_rresp = vecs[i].sresp; sl_rdata = vecs[i].srdata;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb);
            if (vecs[i].wr) check($sformatf("v%0d awaddr", i), {32'd0, m_awaddr}, {32'd0, vecs[i].addr});
            else            check($sformatf("v%0d araddr", i), {32'd0, m_araddr}, {32'd0, vecs[i].addr});
            wait_resp($sformatf("v%0d resp arrives", i));
            if (vecs[i].wr) exp_wr++; else exp_rd++;
            check($sformatf("v%0d write", i), {63'd0, resp_write}, {63'd0, vecs[i].wr});
            check($sformatf("v%0d data", i), {32'd0, resp_data}, {32'd0, vecs[i].exp_data});
            check($sformatf("v%0d err", i), {62'd0, resp_err}, {62'd0, vecs[i].exp_err});
            consume();
            check($sformatf("v%0d idle", i), {62'd0, resp_v, cmd_ready}, 64'b01);
        end
        check("tbl wr_count", {48'd0, wr_count}, 64'(exp_wr));
        check("tbl rd_count", {48'd0, rd_count}, 64'(exp_rd));
        check("no timeout", {63'd0, timeout}, 64'd0);

        // Asynchronous reset in the middle of WR_REQ
        sl_bresp = 2'b00; sl_rresp = 2'b00;
        aw_delay = 50; w_delay = 50;
        issue(1'b1, 32'h60, 32'h1, 4'hF);
        step();
        check("mid-rst pre valids", {62'd0, m_awvalid, m_wvalid}, 64'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid-rst valids", {59'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
        check("mid-rst counters", {32'd0, wr_count, rd_count}, 64'd0);
        check("mid-rst ready/resp", {62'd0, cmd_ready, resp_v}, 64'd0);
        aw_delay = 0; w_delay = 0;
        step();
        reset_n = 1'b1;
        step();
        issue(1'b1, 32'h64, 32'h2, 4'hF);
        wait_resp("post-rst write resp");
        consume();
        check("post-rst wr_count", {48'd0, wr_count}, 64'd1);

`ifdef BSG_FIFOS_TO_AXIL_TIMEOUT_EN
        // Slave never answers b: flag rises 8 cycles after the w handshake
        b_never = 1'b1;
        issue(1'b1, 32'h70, 32'h3, 4'hF);
        for (int cyc = 1; cyc <= 11; cyc++) begin
            check($sformatf("to c%0d", cyc), {63'd0, timeout}, {63'd0, cyc >= 10});
            step();
        end
        check("to still waiting", {61'd0, m_bready, m_awvalid, m_wvalid}, 64'b100);
        reset_n = 1'b0;
        step();
        b_never = 1'b0;
        reset_n = 1'b1;
        step();
        check("to cleared by reset", {63'd0, timeout}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
